armleocpu_decode: RTL
=====================

ARMLEOCPU_DECODE -- requirements
Module: armleocpu_decode

Interface
REQ-001 SHALL have ports: clk in 1 clock; rst_n in 1 synchronous active-low reset.
REQ-002 SHALL have ports from fetch: f2d_valid in 1; f2d_type in F2E_TYPE_WIDTH (INSTR or INTERRUPT_PENDING); f2d_instr in 32; f2d_pc in 32; f2d_resp in 4 cache response.
REQ-003 SHALL have ports to fetch: d2f_ready out 1; d2f_cmd out ARMLEOCPU_D2F_CMD_WIDTH (NONE, FLUSH, START_BRANCH); d2f_branchtarget out 32.
REQ-004 SHALL have ports to execute: d2e_valid out 1; d2e_type out F2E_TYPE_WIDTH; d2e_instr out 32; d2e_pc out 32; d2e_resp out 4; d2e_serialize out 1, set when the instruction needs a pipeline restart.
REQ-005 SHALL have ports from execute: e2d_ready in 1; e2d_cmd in ARMLEOCPU_D2F_CMD_WIDTH; e2d_branchtarget in 32.

Function
REQ-006 SHALL hold one D2E pipeline register: d2e_valid/type/instr/pc/resp/serialize.
REQ-007 SHALL take an F2D transfer when f2d_valid && d2f_ready; latency of 1 clk to d2e_valid.
REQ-008 SHALL clear the D2E register on e2d_ready && d2e_valid, unless a new transfer loads it in the same cycle.
REQ-009 SHALL drive d2f_ready = !f2d_valid || cmd_forward || (state==RUN && (!d2e_valid || e2d_ready)); ready SHALL be 1 whenever f2d_valid=0.
REQ-010 SHALL set cmd_forward = e2d_ready && e2d_cmd!=NONE; then d2f_cmd=e2d_cmd and d2f_branchtarget=e2d_branchtarget, otherwise d2f_cmd=NONE.
REQ-011 SHALL, on cmd_forward, discard any concurrent F2D transfer: d2e_valid<=0 in that cycle.
REQ-012 SHALL set d2e_serialize for opcode SYSTEM (1110011: CSR*, ECALL, EBREAK, xRET, WFI), MISC-MEM funct3=001 (FENCE.I), f2d_type=INTERRUPT_PENDING, or f2d_resp!=CACHE_RESPONSE_SUCCESS.
REQ-013 SHALL implement FSM RUN/SERIALIZE: RUN->SERIALIZE when a serializing entry is taken; SERIALIZE->RUN on cmd_forward; RUN stays RUN otherwise.
REQ-014 SHALL hold d2f_ready=0 in SERIALIZE while f2d_valid=1, except in the cmd_forward cycle.
REQ-015 SHALL, when a serializing entry is taken in the same cycle as cmd_forward, treat the forward as the winner: no entry, state RUN.
REQ-016 SHALL keep d2e_* outputs stable while d2e_valid && !e2d_ready.
REQ-017 SHALL pass f2d_instr unchanged to d2e_instr; no decode of fields beyond REQ-012.
REQ-018 SHALL send an entry with f2d_type=INTERRUPT_PENDING to execute with d2e_instr ignored.
REQ-019 SHALL keep only one execute command in flight: the execute unit issues no second cmd before decode returns to RUN.

Reset
REQ-020 SHALL, with rst_n=0 at a clk edge, reset: d2e_valid=0, d2e_serialize=0, state=RUN.
REQ-021 SHALL, while rst_n=0, drive d2f_cmd=NONE and d2f_ready=1; d2e_instr/pc/resp/type are don't-care.
REQ-022 SHALL, when reset occurs mid-SERIALIZE or with d2e_valid=1, drop the entry and produce no forward.

Structure
REQ-023 SHALL take F2E_TYPE_*, ARMLEOCPU_D2F_CMD_* and CACHE_RESPONSE_* from armleocpu_defines.vh; the opcode constants OPCODE_SYSTEM and OPCODE_FENCE go there too.
REQ-024 SHALL use DEFINE_REG_REG_NXT registers with a single combinational next-state block.
REQ-025 SHALL put the serialize detection in a combinational sub-module, armleocpu_decode_serialize_detect.

Verification
REQ-026 Stream test: 4 back-to-back ADDI at pc 0x1000..0x100C with e2d_ready=1 -> d2e_pc 0x1000..0x100C on consecutive cycles; d2f_ready stays 1.
REQ-027 Backpressure test: e2d_ready=0 for 3 cycles with d2e holding 0x1000 -> d2e stable; d2f_ready=0 while f2d_valid=1; then resumes with no loss or duplicate.
REQ-028 CSR test: CSRRW at 0x2000, then e2d_cmd=START_BRANCH to 0x2004 -> state SERIALIZE; next instr not accepted; d2f_cmd=START_BRANCH with target 0x2004 in one cycle; back to RUN.
REQ-029 Interrupt test: f2d_type=INTERRUPT_PENDING -> d2e_serialize=1; then e2d START_BRANCH to 0x80 forwarded; the F2D transfer in the same cycle is discarded.
REQ-030 Flush test: FENCE.I (0x0000100F) then e2d_cmd=FLUSH -> d2f_cmd=FLUSH for 1 cycle; no branch target used.
REQ-031 Reset test: rst_n=0 while in SERIALIZE with d2e_valid=1 -> next cycle d2e_valid=0, state RUN, d2f_cmd=NONE.

Source files
------------

// File: rtl/armleocpu_decode_pkg.sv
// rtl/armleocpu_decode_pkg.sv - shared constants and types for the decode stage
//
// Purpose: F2E entry types, decode-to-fetch command codes, cache response
// codes, the opcode constants used for serialize detection and the decode
// FSM state type.
package armleocpu_decode_pkg;

  localparam int F2E_TYPE_WIDTH = 2;
  localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INSTR             = 2'd0;
  localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INTERRUPT_PENDING = 2'd1;

  localparam int ARMLEOCPU_D2F_CMD_WIDTH = 2;
  localparam logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] ARMLEOCPU_D2F_CMD_NONE         = 2'd0;
  localparam logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] ARMLEOCPU_D2F_CMD_FLUSH        = 2'd1;
  localparam logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] ARMLEOCPU_D2F_CMD_START_BRANCH = 2'd2;

  localparam logic [3:0] CACHE_RESPONSE_SUCCESS = 4'd0;

  localparam logic [6:0] OPCODE_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPCODE_FENCE   = 7'b0001111;
  localparam logic [2:0] FUNCT3_FENCE_I = 3'b001;

  typedef enum logic {
    STATE_RUN       = 1'b0,
    STATE_SERIALIZE = 1'b1
  } decode_state_t;

endpackage

// File: rtl/armleocpu_decode_serialize_detect.sv
// rtl/armleocpu_decode_serialize_detect.sv - flags entries that need a pipeline restart
//
// Purpose: combinational classification of an F2D entry.
// Ports:
//   f2d_type   - entry type (instruction or interrupt pending)
//   opcode     - instruction bits [6:0]
//   funct3     - instruction bits [14:12]
//   f2d_resp   - cache response for the fetch
//   serialize  - 1 when execute must restart the pipeline after this entry
module armleocpu_decode_serialize_detect
  import armleocpu_decode_pkg::*;
(
  input  logic [F2E_TYPE_WIDTH-1:0] f2d_type,
  input  logic [6:0]                opcode,
  input  logic [2:0]                funct3,
  input  logic [3:0]                f2d_resp,
  output logic                      serialize
);

  always_comb begin
    serialize = 1'b0;
    if (f2d_type == F2E_TYPE_INTERRUPT_PENDING)
      serialize = 1'b1;
    else if (f2d_resp != CACHE_RESPONSE_SUCCESS)
      serialize = 1'b1;
    else if (opcode == OPCODE_SYSTEM)
      serialize = 1'b1;
    else if (opcode == OPCODE_FENCE && funct3 == FUNCT3_FENCE_I)
      serialize = 1'b1;
  end

endmodule

// File: rtl/armleocpu_decode.sv
// rtl/armleocpu_decode.sv - decode stage: one D2E register plus execute command forwarding
//
// Purpose: accepts fetch entries into a single pipeline register towards
// execute, forwards execute commands (flush/branch) back to fetch, and stalls
// fetch after a serializing entry until execute issues its restart command.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   f2d_valid/type/instr/pc/resp     - entry offered by fetch
//   d2f_ready, d2f_cmd, d2f_branchtarget - handshake and command to fetch
//   d2e_valid/type/instr/pc/resp/serialize - registered entry to execute
//   e2d_ready, e2d_cmd, e2d_branchtarget - handshake and command from execute
module armleocpu_decode
  import armleocpu_decode_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,

  input  logic                               f2d_valid,
  input  logic [F2E_TYPE_WIDTH-1:0]          f2d_type,
  input  logic [31:0]                        f2d_instr,
  input  logic [31:0]                        f2d_pc,
  input  logic [3:0]                         f2d_resp,

  output logic                               d2f_ready,
  output logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd,
  output logic [31:0]                        d2f_branchtarget,

  output logic                               d2e_valid,
  output logic [F2E_TYPE_WIDTH-1:0]          d2e_type,
  output logic [31:0]                        d2e_instr,
  output logic [31:0]                        d2e_pc,
  output logic [3:0]                         d2e_resp,
  output logic                               d2e_serialize,

  input  logic                               e2d_ready,
  input  logic [ARMLEOCPU_D2F_CMD_WIDTH-1:0] e2d_cmd,
  input  logic [31:0]                        e2d_branchtarget
);

  decode_state_t               state, state_nxt;
  logic                        d2e_valid_nxt;
  logic [F2E_TYPE_WIDTH-1:0]   d2e_type_nxt;
  logic [31:0]                 d2e_instr_nxt;
  logic [31:0]                 d2e_pc_nxt;
  logic [3:0]                  d2e_resp_nxt;
  logic                        d2e_serialize_nxt;

  logic cmd_forward;
  logic f2d_take;
  logic serialize_detected;

  armleocpu_decode_serialize_detect u_serialize_detect (
    .f2d_type  (f2d_type),
    .opcode    (f2d_instr[6:0]),
    .funct3    (f2d_instr[14:12]),
    .f2d_resp  (f2d_resp),
    .serialize (serialize_detected)
  );

  assign cmd_forward = e2d_ready && (e2d_cmd != ARMLEOCPU_D2F_CMD_NONE);

  // Ready is forced high in reset so fetch never sees a stall it cannot leave.
  assign d2f_ready = !rst_n || !f2d_valid || cmd_forward ||
                     (state == STATE_RUN && (!d2e_valid || e2d_ready));
  assign d2f_cmd          = (rst_n && cmd_forward) ? e2d_cmd : ARMLEOCPU_D2F_CMD_NONE;
  assign d2f_branchtarget = e2d_branchtarget;

  // A forwarded command redirects fetch, so whatever fetch offers that cycle
  // is from the old path and is dropped.
  assign f2d_take = f2d_valid && d2f_ready && !cmd_forward;

  always_comb begin
    state_nxt         = state;
    d2e_valid_nxt     = d2e_valid;
    d2e_type_nxt      = d2e_type;
    d2e_instr_nxt     = d2e_instr;
    d2e_pc_nxt        = d2e_pc;
    d2e_resp_nxt      = d2e_resp;
    d2e_serialize_nxt = d2e_serialize;

    if (d2e_valid && e2d_ready) begin
      d2e_valid_nxt     = 1'b0;
      d2e_serialize_nxt = 1'b0;
    end

    // Load after the consume so a same-cycle refill wins over the clear.
    if (f2d_take) begin
      d2e_valid_nxt     = 1'b1;
      d2e_type_nxt      = f2d_type;
      d2e_instr_nxt     = f2d_instr;
      d2e_pc_nxt        = f2d_pc;
      d2e_resp_nxt      = f2d_resp;
      d2e_serialize_nxt = serialize_detected;
      if (serialize_detected)
        state_nxt = STATE_SERIALIZE;
    end

    if (cmd_forward)
      state_nxt = STATE_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= STATE_RUN;
      d2e_valid     <= 1'b0;
      d2e_serialize <= 1'b0;
    end else begin
      state         <= state_nxt;
      d2e_valid     <= d2e_valid_nxt;
      d2e_serialize <= d2e_serialize_nxt;
    end
  end

  // Payload carries no reset; it is only meaningful while d2e_valid is set.
  always_ff @(posedge clk) begin
    d2e_type  <= d2e_type_nxt;
    d2e_instr <= d2e_instr_nxt;
    d2e_pc    <= d2e_pc_nxt;
    d2e_resp  <= d2e_resp_nxt;
  end

endmodule
